// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The optional trailing checksum word is enabled by defining
// PROGRAM_LOADER_CHECKSUM_EN. This package itself is identical in both builds.
package program_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [WORD_W-1:0] word_t;

    // Loader FSM states.
    // CSUM_HI and CSUM_LO are only reachable when the checksum feature is built in.
    typedef enum logic [3:0] {
        LEN_HI  = 4'd0,
        LEN_LO  = 4'd1,
        DATA_HI = 4'd2,
        DATA_LO = 4'd3,
        WRITE   = 4'd4,
        CSUM_HI = 4'd5,
        CSUM_LO = 4'd6,
        DONE    = 4'd7,
        ERROR   = 4'd8
    } state_t;

    // States in which the loader is waiting for, and will take, a stream byte.
    function automatic logic accepts_byte(input state_t s);
        return (s == LEN_HI)  || (s == LEN_LO)  ||
               (s == DATA_HI) || (s == DATA_LO) ||
               (s == CSUM_HI) || (s == CSUM_LO);
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Pairs big-endian bytes into 16-bit words for the program loader.
// With PROGRAM_LOADER_CHECKSUM_EN defined, it also keeps a running XOR of
// the data words that the FSM marks for accumulation.
module loader_word_assembler
    import program_loader_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  byte_valid,
    input  byte_t byte_data,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    input  logic  accumulate,
    output word_t checksum,
`endif
    output word_t word,
    output logic  word_complete
);

    logic  low_phase;
    byte_t high_byte;

    // Track the high/low phase and keep the high byte until its partner arrives.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            low_phase <= 1'b0;
            high_byte <= '0;
        end else if (byte_valid) begin
            if (!low_phase) begin
                high_byte <= byte_data;
            end
            low_phase <= ~low_phase;
        end
    end

    // The word is complete in the cycle the low byte is presented and taken.
    assign word          = {high_byte, byte_data};
    assign word_complete = byte_valid && low_phase;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    word_t xor_acc;

    // Running XOR over all data words, starting from zero after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            xor_acc <= '0;
        end else if (accumulate) begin
            xor_acc <= xor_acc ^ word;
        end
    end

    assign checksum = xor_acc;
`endif

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: takes a length-prefixed big-endian image from a
// byte stream and writes it to consecutive RAM words. The CPU is held in reset
// until the image is complete. Define PROGRAM_LOADER_CHECKSUM_EN to require a
// trailing XOR checksum word.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_write_enable,
    output logic [15:0] mem_address,
    output logic [15:0] mem_write_data,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    // Length limit widened by one bit so that MAX_WORDS = 65536 still compares correctly.
    localparam logic [16:0] MAX_WORDS_LIMIT = 17'(MAX_WORDS);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CSUM_HI;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t state;
    state_t next_state;
    word_t  word_count;
    word_t  index;
    word_t  index_next;
    word_t  word;
    logic   accept;
    logic   word_complete;
    logic   len_too_big;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    word_t  checksum;
    logic   accumulate;

    assign accumulate = (state == DATA_LO) && word_complete;
`endif

    assign accept      = rx_valid && rx_ready;
    assign index_next  = index + 16'd1;
    assign len_too_big = {1'b0, word} > MAX_WORDS_LIMIT;

    loader_word_assembler u_assembler (
        .clock         (clock),
        .reset         (reset),
        .byte_valid    (accept),
        .byte_data     (rx_data),
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        .accumulate    (accumulate),
        .checksum      (checksum),
`endif
        .word          (word),
        .word_complete (word_complete)
    );

    // State register; an asserted reset restarts the load from LEN_HI.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= LEN_HI;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: walk the image format, ending in DONE or ERROR.
    always_comb begin
        next_state = state;
        unique case (state)
            LEN_HI: begin
                if (accept) next_state = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    if (word == '0)       next_state = AFTER_DATA;
                    else if (len_too_big) next_state = ERROR;
                    else                  next_state = DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) next_state = DATA_LO;
            end
            DATA_LO: begin
                if (accept) next_state = WRITE;
            end
            WRITE: begin
                if (index_next < word_count) next_state = DATA_HI;
                else                         next_state = AFTER_DATA;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CSUM_HI: begin
                if (accept) next_state = CSUM_LO;
            end
            CSUM_LO: begin
                if (accept) next_state = (word == checksum) ? DONE : ERROR;
            end
`else
            CSUM_HI, CSUM_LO: begin
                next_state = ERROR;
            end
`endif
            DONE:    next_state = DONE;
            ERROR:   next_state = ERROR;
            default: next_state = LEN_HI;
        endcase
    end

    // Word count, write index and the registered RAM address/data that hold outside WRITE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_count     <= '0;
            index          <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            if ((state == LEN_LO) && word_complete) begin
                word_count <= word;
                index      <= '0;
            end
            if ((state == DATA_LO) && word_complete) begin
                mem_address    <= BASE_ADDR + index;
                mem_write_data <= word;
            end
            if (state == WRITE) begin
                index <= index_next;
            end
        end
    end

    assign rx_ready         = accepts_byte(state);
    assign mem_write_enable = (state == WRITE);
    assign cpu_reset        = (state == DONE);
    assign done             = (state == DONE);
    assign error            = (state == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader. Two loaders share one byte stream:
// one based at 0x0000 and one at 0xFFFF so address wrap is seen on every image.
// Honours PROGRAM_LOADER_CHECKSUM_EN the same way the design does.
module tb_program_loader;

    localparam int MAX_WORDS = 4096;
    localparam logic [15:0] BASE0 = 16'h0000;
    localparam logic [15:0] BASE1 = 16'hFFFF;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready [2];
    logic        mem_we [2];
    logic [15:0] mem_addr [2];
    logic [15:0] mem_data [2];
    logic        cpu_reset [2];
    logic        done [2];
    logic        error [2];

    int          checks = 0;
    int          passes = 0;
    int          acc_bytes = 0;
    int          rd_ptr [2];
    logic [15:0] exp_data [$];
    logic [15:0] img_words [$];
    logic [15:0] seen_addr1 [$];
    logic [15:0] last_xor;

    always #5 clock = ~clock;

    program_loader #(.BASE_ADDR(BASE0), .MAX_WORDS(MAX_WORDS)) dut0 (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready[0]), .mem_write_enable(mem_we[0]), .mem_address(mem_addr[0]),
        .mem_write_data(mem_data[0]), .cpu_reset(cpu_reset[0]), .done(done[0]), .error(error[0])
    );

    program_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(MAX_WORDS)) dut1 (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready[1]), .mem_write_enable(mem_we[1]), .mem_address(mem_addr[1]),
        .mem_write_data(mem_data[1]), .cpu_reset(cpu_reset[1]), .done(done[1]), .error(error[1])
    );

    function automatic logic [15:0] base_of(input int i);
        return (i == 0) ? BASE0 : BASE1;
    endfunction

    function automatic logic [15:0] model_xor(input int n);
        logic [15:0] x = 16'h0000;
        for (int k = 0; k < n; k++) x = x ^ img_words[k];
        return x;
    endfunction

    task automatic checkOutput(input string name, input int inst,
                               input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s[%0d]: actual=%0h required=%0h", name, inst, act, req);
    endtask

    // Every write strobe must be the next expected word, at base+index, one cycle after its low byte.
    always @(posedge clock) begin
        logic [15:0] exp_addr;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                rd_ptr[i] = 0;
                if (i == 1) seen_addr1.delete();
            end else if (mem_we[i]) begin
                if (rd_ptr[i] >= exp_data.size()) begin
                    checkOutput("unexpected_write", i, 32'(1), 32'(0));
                end else begin
                    exp_addr = base_of(i) + 16'(rd_ptr[i]);
                    checkOutput("write_address", i, 32'(mem_addr[i]), 32'(exp_addr));
                    checkOutput("write_data", i, 32'(mem_data[i]), 32'(exp_data[rd_ptr[i]]));
                    checkOutput("write_latency_bytes", i, 32'(acc_bytes), 32'(2 + 2 * (rd_ptr[i] + 1)));
                    checkOutput("ready_low_in_write", i, 32'(rx_ready[i]), 32'(0));
                    if (i == 1) seen_addr1.push_back(mem_addr[i]);
                    rd_ptr[i]++;
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 2; i++) begin
            checkOutput({tag, "_rx_ready"}, i, 32'(rx_ready[i]), 32'(1));
            checkOutput({tag, "_write_enable"}, i, 32'(mem_we[i]), 32'(0));
            checkOutput({tag, "_address"}, i, 32'(mem_addr[i]), 32'(0));
            checkOutput({tag, "_write_data"}, i, 32'(mem_data[i]), 32'(0));
            checkOutput({tag, "_cpu_reset"}, i, 32'(cpu_reset[i]), 32'(0));
            checkOutput({tag, "_done"}, i, 32'(done[i]), 32'(0));
            checkOutput({tag, "_error"}, i, 32'(error[i]), 32'(0));
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        rx_valid = 1'b0;
        acc_bytes = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Called on a negedge; returns on the negedge after the byte has been taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        if (gap > 0) begin
            rx_valid = 1'b0;
            rx_data  = 8'h00;
            repeat (gap) @(negedge clock);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready[0] && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) begin
            checkOutput("byte_accept_timeout", 0, 32'(0), 32'(1));
        end else begin
            acc_bytes++;
            @(negedge clock);
        end
    endtask

    // Sends an image of n words (from img_words) and checks the outcome the format rules require.
    task automatic applyStimulus(input logic [15:0] n, input logic [15:0] csum, input int gap);
        bit too_big = (int'(n) > MAX_WORDS);
        bit want_done;
        int t = 0;
        exp_data.delete();
        last_xor = 16'h0000;
        if (!too_big) begin
            for (int k = 0; k < int'(n); k++) exp_data.push_back(img_words[k]);
            last_xor = model_xor(int'(n));
        end
        want_done = !too_big && !(CSUM_EN && (last_xor != csum));

        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        if (!too_big) begin
            for (int k = 0; k < int'(n); k++) begin
                send_byte(img_words[k][15:8], gap);
                send_byte(img_words[k][7:0], gap);
            end
            if (CSUM_EN) begin
                send_byte(csum[15:8], gap);
                send_byte(csum[7:0], gap);
            end
        end
        rx_valid = 1'b0;

        while (!(done[0] || error[0]) && t < 20) begin
            @(negedge clock);
            t++;
        end
        checkOutput("reached_terminal", 0, 32'(done[0] || error[0]), 32'(1));

        // Hold rx_valid high in the terminal state: nothing may be consumed or written.
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (4) begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) checkOutput("ready_low_terminal", i, 32'(rx_ready[i]), 32'(0));
        end
        rx_valid = 1'b0;

        for (int i = 0; i < 2; i++) begin
            checkOutput("done", i, 32'(done[i]), 32'(want_done));
            checkOutput("error", i, 32'(error[i]), 32'(!want_done));
            checkOutput("cpu_reset", i, 32'(cpu_reset[i]), 32'(want_done));
            checkOutput("write_count", i, 32'(rd_ptr[i]), 32'(exp_data.size()));
        end
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1 reset = 1'b0;
        #2 check_reset_values("por");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Three words back-to-back.
        $display("[TB] image N=3 back-to-back");
        img_words = '{16'h1234, 16'hABCD, 16'h0001};
        applyStimulus(16'd3, 16'hB9F8, 0);
        checkOutput("model_xor_pin", 0, 32'(last_xor), 32'(16'hB9F8));
        checkOutput("wrap_addr_count", 1, 32'(seen_addr1.size()), 32'(3));
        if (seen_addr1.size() == 3) begin
            checkOutput("wrap_addr0", 1, 32'(seen_addr1[0]), 32'(16'hFFFF));
            checkOutput("wrap_addr1", 1, 32'(seen_addr1[1]), 32'(16'h0000));
            checkOutput("wrap_addr2", 1, 32'(seen_addr1[2]), 32'(16'h0001));
        end

        // Same image with rx_valid dropping between every byte.
        $display("[TB] image N=3 with gaps");
        do_reset();
        applyStimulus(16'd3, 16'hB9F8, 1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        $display("[TB] image N=3 with wrong checksum");
        do_reset();
        applyStimulus(16'd3, 16'hB9F9, 0);
`else
        $display("[TB] image N=1 with gaps of two");
        do_reset();
        img_words = '{16'h8000};
        applyStimulus(16'd1, 16'h8000, 2);
`endif

        $display("[TB] empty image");
        do_reset();
        applyStimulus(16'd0, 16'h0000, 0);

        $display("[TB] over-length image");
        do_reset();
        applyStimulus(16'h1001, 16'h0000, 0);

        $display("[TB] N=2 address wrap");
        do_reset();
        img_words = '{16'h5A5A, 16'h0F0F};
        applyStimulus(16'd2, 16'h5555, 0);
        checkOutput("wrap2_addr_count", 1, 32'(seen_addr1.size()), 32'(2));
        if (seen_addr1.size() == 2) begin
            checkOutput("wrap2_addr0", 1, 32'(seen_addr1[0]), 32'(16'hFFFF));
            checkOutput("wrap2_addr1", 1, 32'(seen_addr1[1]), 32'(16'h0000));
        end

        $display("[TB] N=MAX_WORDS boundary");
        do_reset();
        img_words.delete();
        for (int k = 0; k < MAX_WORDS; k++) img_words.push_back(16'(k * 257) ^ 16'h3C00);
        applyStimulus(16'(MAX_WORDS), model_xor(MAX_WORDS), 0);

        // Reset after two of three words, then a fresh single-word image.
        $display("[TB] reset mid-load");
        do_reset();
        img_words = '{16'h1234, 16'hABCD, 16'h0001};
        exp_data  = '{16'h1234, 16'hABCD};
        send_byte(8'h00, 0); send_byte(8'h03, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'hAB, 0); send_byte(8'hCD, 0);
        rx_valid = 1'b0;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 2; i++) checkOutput("partial_writes", i, 32'(rd_ptr[i]), 32'(2));
        #1 reset = 1'b0;
        #1 check_reset_values("midload");
        acc_bytes = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        img_words = '{16'hBEEF};
        applyStimulus(16'd1, 16'hBEEF, 0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
